// File: rtl/fifo_to_com_if.sv
// fifo_to_com_if: FIFO read port, UART tx line and status bundle of the FIFO-to-UART transmitter.
interface fifo_to_com_if;
    logic       start;
    logic       fifo_empty;
    logic       fifo_busy;
    logic [7:0] fifo_data;
    logic       fifo_re;
    logic       tx;
    logic       busy;
    logic       finish;
    logic [7:0] crc;
    logic [9:0] byte_count;

    modport master (
        output start, fifo_empty, fifo_busy, fifo_data,
        input  fifo_re, tx, busy, finish, crc, byte_count
    );

    modport slave (
        input  start, fifo_empty, fifo_busy, fifo_data,
        output fifo_re, tx, busy, finish, crc, byte_count
    );
endinterface

// File: rtl/fifo_to_com.sv
// fifo_to_com: drains the byte FIFO as 8N1 UART frames on tx, then appends a CRC-8 (poly 0x07) frame.
module fifo_to_com #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic          clk,
    input logic          reset,
    fifo_to_com_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, LOAD, SEND, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] frame_q, frame_d;
    logic [7:0] crc_q, crc_d, crc_next;
    logic [9:0] cnt_q, cnt_d;
    logic       crc_flag_q, crc_flag_d;
    logic       bit_end;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign crc_next = crc8(crc_q, bus.fifo_data);
    assign bit_end  = clk_cnt_q == 8'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '1;
            crc_q      <= '0;
            cnt_q      <= '0;
            crc_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            crc_flag_q <= crc_flag_d;
        end
    end

    // frame_q holds {stop, data, start} and shifts right once per bit, so tx is always bit 0
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        crc_flag_d = crc_flag_q;
        case (state_q)
            IDLE: if (bus.start) begin
                crc_d   = '0;
                cnt_d   = '0;
                state_d = CHECK;
            end
            CHECK: if (!bus.fifo_busy) begin
                clk_cnt_d  = '0;
                bit_cnt_d  = '0;
                frame_d    = {1'b1, crc_q, 1'b0};
                crc_flag_d = bus.fifo_empty;
                state_d    = bus.fifo_empty ? SEND : LOAD;
            end
            LOAD: begin
                frame_d = {1'b1, bus.fifo_data, 1'b0};
                crc_d   = crc_next;
                cnt_d   = &cnt_q ? cnt_q : cnt_q + 10'd1;
                state_d = SEND;
            end
            SEND: if (bit_end) begin
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 4'd1;
                frame_d   = {1'b1, frame_q[9:1]};
                if (bit_cnt_q == 4'd9) state_d = crc_flag_q ? DONE : CHECK;
            end else begin
                clk_cnt_d = clk_cnt_q + 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset forces tx high and fifo_re low without a clock
    assign bus.fifo_re    = state_q == CHECK && !bus.fifo_busy && !bus.fifo_empty;
    assign bus.tx         = state_q == SEND ? frame_q[0] : 1'b1;
    assign bus.busy       = state_q != IDLE;
    assign bus.finish     = state_q == DONE;
    assign bus.crc        = crc_q;
    assign bus.byte_count = cnt_q;
endmodule

// File: tb/tb_fifo_to_com.sv
// tb_fifo_to_com: directed checks of fifo_to_com frames, CRC, gaps, fifo_busy stall, mid-frame reset and ignored start.
module tb_fifo_to_com;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   re_cnt = 0;
    int   fin_cnt = 0;
    int   rd = 0;
    int   wr = 0;
    logic [7:0] mem [64];

    fifo_to_com_if bus ();

    fifo_to_com #(.CLKS_PER_BIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty = (rd == wr);

    always @(posedge clk) begin
        if (bus.fifo_re) begin
            bus.fifo_data <= mem[rd];
            rd            <= rd + 1;
            re_cnt        <= re_cnt + 1;
        end
        if (bus.finish) fin_cnt <= fin_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr] = b;
        wr++;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // counts tx-high cycles up to the next start bit; optionally holds fifo_busy for `hold` CHECK cycles
    task automatic wait_start(input int hold, output int gap);
        gap = 0;
        while (bus.tx && gap < 200) begin
            gap++;
            if (gap <= hold) check("re_while_busy", bus.fifo_re, 0);
            if (gap == hold) begin
                @(posedge clk);
                #1 bus.fifo_busy = 1'b0;
            end
            @(negedge clk);
        end
        check("start_bit_seen", bus.tx, 0);
    endtask

    // samples one 40-cycle frame; ev 1 raises fifo_busy, 2 drops reset, 3 pulses start, at sample ev_k
    task automatic recv_frame(input logic [7:0] exp, input string tag, input int ev_k, input int ev);
        logic [39:0] s;
        logic [7:0]  b;
        for (int k = 0; k < 40; k++) begin
            s[k] = bus.tx;
            if (k == ev_k && ev == 1) bus.fifo_busy = 1'b1;
            if (k == ev_k && ev == 3) bus.start = 1'b1;
            if (k == ev_k + 1 && ev == 3) bus.start = 1'b0;
            if (k == ev_k && ev == 2) begin
                reset = 1'b0;
                #1;
                check("rst_tx", bus.tx, 1);
                check("rst_re", bus.fifo_re, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_crc", bus.crc, 0);
                return;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) b[i] = s[4 * i + 5];
        check({tag, "_start"}, s[3:0], 0);
        check({tag, "_stop"}, s[39:36], 4'hF);
        check(tag, b, exp);
    endtask

    task automatic tail(input logic [7:0] exp_crc, input logic [9:0] exp_cnt);
        check("finish_pulse", bus.finish, 1);
        check("crc_final", bus.crc, exp_crc);
        check("byte_count", bus.byte_count, exp_cnt);
        @(negedge clk);
        check("finish_low", bus.finish, 0);
        check("busy_low", bus.busy, 0);
        check("crc_held", bus.crc, exp_crc);
    endtask

    initial begin
        int g, f0, r0;
        bus.start     = 1'b0;
        bus.fifo_busy = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", bus.tx, 1);
        check("reset_re", bus.fifo_re, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_finish", bus.finish, 0);
        check("reset_crc", bus.crc, 0);
        check("reset_count", bus.byte_count, 0);
        reset = 1'b1;
        @(negedge clk);

        // single byte, with a start pulse mid-frame that must be ignored
        push(8'h31);
        f0 = fin_cnt;
        pulse_start();
        check("busy_after_start", bus.busy, 1);
        wait_start(0, g);
        check("gap_first", g, 2);
        recv_frame(8'h31, "t1_data", 20, 3);
        wait_start(0, g);
        check("gap_crc", g, 1);
        recv_frame(8'h97, "t1_crc", -5, 0);
        tail(8'h97, 10'd1);
        repeat (5) @(negedge clk);
        check("t1_one_finish", fin_cnt - f0, 1);
        check("t1_no_restart", bus.busy, 0);

        // two bytes
        push(8'h31);
        push(8'h32);
        r0 = re_cnt;
        pulse_start();
        wait_start(0, g);
        recv_frame(8'h31, "t2_d0", -5, 0);
        wait_start(0, g);
        check("t2_gap", g, 2);
        recv_frame(8'h32, "t2_d1", -5, 0);
        wait_start(0, g);
        recv_frame(8'h72, "t2_crc", -5, 0);
        tail(8'h72, 10'd2);
        check("t2_re_count", re_cnt - r0, 2);

        // empty FIFO: only a zero CRC frame
        repeat (2) @(negedge clk);
        pulse_start();
        wait_start(0, g);
        check("t3_gap", g, 1);
        recv_frame(8'h00, "t3_crc", -5, 0);
        tail(8'h00, 10'd0);

        // fifo_busy held for 5 CHECK cycles between frames
        push(8'h31);
        push(8'h32);
        pulse_start();
        wait_start(0, g);
        recv_frame(8'h31, "t4_d0", 39, 1);
        wait_start(5, g);
        check("t4_gap_stretched", g, 7);
        recv_frame(8'h32, "t4_d1", -5, 0);
        wait_start(0, g);
        recv_frame(8'h72, "t4_crc", -5, 0);
        tail(8'h72, 10'd2);

        // reset during data bit 3 of the first frame, then restart with the remaining byte
        push(8'h55);
        push(8'hA3);
        f0 = fin_cnt;
        pulse_start();
        wait_start(0, g);
        recv_frame(8'h55, "t5_d0", 17, 2);
        repeat (3) @(negedge clk);
        check("t5_no_finish", fin_cnt - f0, 0);
        check("t5_tx_idle", bus.tx, 1);
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_start(0, g);
        recv_frame(8'hA3, "t5_d1", -5, 0);
        wait_start(0, g);
        recv_frame(8'h60, "t5_crc", -5, 0);
        tail(8'h60, 10'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/fifo_to_com.md
# fifo_to_com

Transmit-side counterpart of the UART-to-FIFO receive path. On a start pulse it drains the shared byte FIFO and sends each byte as an 8N1 UART frame on `tx`. It then appends one CRC-8 byte computed over the data bytes sent. It sits between the FIFO read port and the board `tx` pin, clocked by the same divided `clk` as the receive path.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit; legal range 1..255.
- `clk`  in  1: divided system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low; while low, every register takes its reset value.
- `start`  in  1: one-cycle request to begin a transmission; sampled only in IDLE.
- `fifo_empty`  in  1: FIFO has no data.
- `fifo_busy`  in  1: FIFO port unavailable this cycle.
- `fifo_data`  in  8: FIFO read data; valid the cycle after `fifo_re`.
- `fifo_re`  out  1: one-cycle FIFO read strobe.
- `tx`  out  1: UART serial output; idle high.
- `busy`  out  1: high from the cycle after `start` is accepted until `finish`.
- `finish`  out  1: one-cycle pulse after the CRC frame's stop bit completes.
- `crc`  out  8: running CRC; final value held after `finish` until the next start.
- `byte_count`  out  10: data bytes sent in the current/last transmission (CRC byte excluded).

## Operation
- Reset values: `tx`=1, `fifo_re`=0, `busy`=0, `finish`=0, `crc`=0x00, `byte_count`=0, state IDLE.
- States:
  - IDLE: on `start`, clear `crc` and `byte_count`, set `busy`, go to CHECK. `start` outside IDLE is ignored.
  - CHECK:
    - `fifo_busy`=1: stay.
    - otherwise, `fifo_empty`=0: pulse `fifo_re`, go to LOAD.
    - otherwise, `fifo_empty`=1: load shift register with `crc`, go to SEND with a CRC flag.
  - LOAD: latch `fifo_data` into shift register; update `crc`; increment `byte_count`; go to SEND.
  - SEND: output start bit (0), data bits LSB first, stop bit (1), each `CLKS_PER_BIT` cycles.
    - At the end of the stop bit, with data flag: go to CHECK.
    - At the end of the stop bit, with CRC flag: go to DONE.
  - DONE: pulse `finish` for one cycle, clear `busy`, go to IDLE.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Per byte: crc ^= byte, then 8 iterations of shift-left with conditional XOR 0x07.
  - Computed combinationally in LOAD.
- The CRC byte is transmitted LSB first, like data.
- Empty FIFO at `start`: no data frames; one CRC frame 0x00 is sent; `byte_count`=0.
- `byte_count` saturates at 1023 and does not wrap; transmission continues.
- Data written to the FIFO during a transmission is sent, provided the FIFO is non-empty when CHECK samples it.

## Timing
- `start` accepted at edge N (IDLE → CHECK).
- Edge N+1: `fifo_re`=1 in CHECK, if the FIFO is non-empty and not busy.
- Edge N+2: LOAD latches data.
- Edge N+3 onward: start bit on `tx`.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles.
- Inter-frame gap: 2 cycles of `tx`=1 (CHECK + LOAD) when the FIFO is ready; longer while `fifo_busy` holds.
- CRC frame: starts 1 cycle after CHECK sees empty. `finish` is high in the cycle following the CRC stop bit's last cycle.
- `fifo_re` is never high in two consecutive cycles and never high while `fifo_busy`=1 or `fifo_empty`=1.
- `reset` low at any time, including mid-frame:
  - `tx`=1 and `fifo_re`=0 immediately, without waiting for a clock edge.
  - No `finish` is generated.
  - A byte already read from the FIFO is lost.

## Test plan
- `CLKS_PER_BIT`=4, FIFO holds 0x31, pulse `start`:
  - `tx` sends 0x31 frame (bits 1,0,0,0,1,1,0,0 after start bit), then CRC frame 0x97.
  - `finish` pulses; `crc`=0x97, `byte_count`=1.
- FIFO holds 0x31, 0x32:
  - Two data frames, each separated by a 2-cycle high gap, then CRC 0x72.
  - `byte_count`=2; `fifo_re` pulsed exactly twice.
- Empty FIFO, `start`: a single frame of 0x00 (start bit plus 8 zeros, stop bit); `finish`; `byte_count`=0.
- `fifo_busy` held high for 5 cycles in CHECK: `fifo_re` stays 0 for those cycles; the gap stretches to 7 cycles; CRC still correct.
- `reset` low during bit 3 of the first frame:
  - `tx`=1 asynchronously; `busy`=0, `crc`=0.
  - A later `start` transmits the remaining FIFO bytes normally.
- `start` pulsed while `busy`: ignored; the transmission completes with exactly one `finish`.
